instruction_fetch: RTL

Front-end fetch stage of the RV32 core. It owns the program counter, issues word-aligned requests to instruction memory, and buffers returned words with their PCs in a small in-order queue. It presents one instruction per cycle to the decode stage, which sits directly downstream, over a valid/ready handshake. Jump redirects (JAL/JALR targets resolved downstream) flush the queue and discard responses that are still in flight.

---
 rtl/instruction_fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 34 +++
 rtl/instruction_fetch.sv | 76 +++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared core types and constants for the fetch front end
package instruction_fetch_pkg;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int INSTR_W = 32;
   typedef struct packed {
      logic [31:0] pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous flushable FIFO of fetch entries with push/pop/flush/count
module fetch_fifo
   import instruction_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic reset,
   input logic push,
   input fetch_entry_t push_data,
   input logic pop,
   input logic flush,
   output fetch_entry_t pop_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= push_data;
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32 fetch stage (PC, credits, redirect drop); FETCH_ALIGN_CHECK_EN adds misaligned-redirect fault
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input logic clk,
   input logic reset,
   output logic imem_req_valid,
   input logic imem_req_ready,
   output logic [31:0] imem_req_addr,
   input logic imem_resp_valid,
   input logic [INSTR_W-1:0] imem_resp_data,
   input logic redirect_valid,
   input logic [31:0] redirect_target,
   output logic instr_valid,
   input logic instr_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic [31:0] instr_pc,
   output logic fetch_fault
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 1;
   logic [31:0] fetch_pc, resp_pc, target;
   logic [CW-1:0] inflight, drop, count;
   logic fault, req_fire, resp_keep, deq;
   fetch_entry_t head, push_data;
   assign target = redirect_target & ~32'h3;
   assign imem_req_valid = !reset && !redirect_valid && !fault &&
                           (({1'b0, inflight} + {1'b0, count}) < SW'(FIFO_DEPTH));
   assign imem_req_addr = fetch_pc;
   assign req_fire = imem_req_valid && imem_req_ready;
   assign resp_keep = imem_resp_valid && drop == '0 && !redirect_valid;
   assign instr_valid = count != '0 && !fault;
   assign deq = instr_valid && instr_ready && !redirect_valid;
   assign instruction = instr_valid ? head.instr : '0;
   assign instr_pc = instr_valid ? head.pc : '0;
   assign push_data = '{pc: resp_pc, instr: imem_resp_data};
   assign fetch_fault = fault;
`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk)
      if (reset) fault <= 1'b0;
      else if (redirect_valid && redirect_target[1:0] != 2'b00) fault <= 1'b1;
`else
   assign fault = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc <= RESET_PC;
         inflight <= '0;
         drop <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= target;
         resp_pc <= target;
         inflight <= inflight - CW'(imem_resp_valid);
         drop <= inflight - CW'(imem_resp_valid);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + 32'd4;
         if (resp_keep) resp_pc <= resp_pc + 32'd4;
         if (imem_resp_valid && drop != '0) drop <= drop - CW'(1);
         inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
      end
   end
   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(resp_keep),
      .push_data(push_data),
      .pop(deq),
      .flush(redirect_valid),
      .pop_data(head),
      .count(count)
   );
endmodule
